adder_share_sequencer: RTL and testbench

Multi-cycle controller that shares one external N_W-bit ripple adder between two requesters. It arbitrates round-robin between the requesters and adds OP_W = N_W*CHUNKS-bit operands one N_W-bit chunk per cycle, LSB chunk first. The carry is held in a register between chunks. The full-width sum and carry-out are returned on a valid/ready response channel tagged with the requester id.

---
 rtl/adder_share_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_adder_share_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_sequencer.sv
// -----------------------------------------------------------------------------
// adder_share_sequencer
//
// Purpose:
//    Shares a single external N_W-bit ripple adder between two requesters.
//    A round-robin arbiter picks one operation at a time. Its OP_W-bit
//    operands are added one N_W-bit chunk per cycle, least significant chunk
//    first, with the carry held in a register between chunks. The full-width
//    sum and the final carry-out are returned on a valid/ready response
//    channel, tagged with the id of the requester that owns the result.
//
// Parameters:
//    N_W     width of the shared adder (one chunk)
//    CHUNKS  chunks per operation (>= 1); OP_W = N_W*CHUNKS
//
// Ports:
//    clk, rst                 rising-edge clock, asynchronous active-high reset
//    req0_valid / req0_ready  requester 0 handshake (ready = accepted this cycle)
//    req0_a, req0_b           requester 0 operands (sampled on accept only)
//    req1_valid / req1_ready  requester 1 handshake
//    req1_a, req1_b           requester 1 operands
//    add_a, add_b, add_c      chunk operands and carry-in to the shared adder
//                             (held at 0 outside the RUN state)
//    add_sum, add_carry       combinational result returned by the shared adder
//    rsp_valid / rsp_ready    response handshake
//    rsp_id                   requester that owns the result
//    rsp_sum, rsp_carry       full-width sum and carry-out of the top chunk
// -----------------------------------------------------------------------------
module adder_share_sequencer #(
   parameter  int N_W    = 2,
   parameter  int CHUNKS = 4,
   localparam int OP_W   = N_W * CHUNKS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OP_W-1:0] req0_a,
   input  logic [OP_W-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OP_W-1:0] req1_a,
   input  logic [OP_W-1:0] req1_b,
   output logic [N_W-1:0]  add_a,
   output logic [N_W-1:0]  add_b,
   output logic            add_c,
   input  logic [N_W-1:0]  add_sum,
   input  logic            add_carry,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [OP_W-1:0] rsp_sum,
   output logic            rsp_carry
);

   // Chunk index needs at least one bit even when there is a single chunk.
   localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;

   logic [OP_W-1:0]   a_r;
   logic [OP_W-1:0]   b_r;
   logic [OP_W-1:0]   sum_r;
   logic              carry_r;
   logic [IDX_W-1:0]  idx_r;
   logic              id_r;
   logic              last_grant_r;

   logic              grant_s;
   logic              grant_valid_s;
   logic              last_chunk_s;
   logic [N_W-1:0]    chunk_a_s;
   logic [N_W-1:0]    chunk_b_s;
   logic [OP_W-1:0]   sum_next_s;
   logic [OP_W-1:0]   acc_a_s;
   logic [OP_W-1:0]   acc_b_s;

   // Round-robin arbitration: a lone requester always wins; under contention
   // the requester that did not win last time gets the grant.
   always_comb begin
      grant_s       = 1'b0;
      grant_valid_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_valid_s = 1'b1;
         grant_s       = ~last_grant_r;
      end else if (req0_valid) begin
         grant_valid_s = 1'b1;
         grant_s       = 1'b0;
      end else if (req1_valid) begin
         grant_valid_s = 1'b1;
         grant_s       = 1'b1;
      end else begin
         grant_valid_s = 1'b0;
         grant_s       = 1'b0;
      end
   end

   // Operand selection at acceptance time, driven by the winning requester.
   always_comb begin
      acc_a_s = req0_a;
      acc_b_s = req0_b;
      if (grant_s) begin
         acc_a_s = req1_a;
         acc_b_s = req1_b;
      end else begin
         acc_a_s = req0_a;
         acc_b_s = req0_b;
      end
   end

   assign last_chunk_s = (idx_r == IDX_W'(CHUNKS - 1));

   // Chunk multiplexer: pick the slice selected by idx_r out of the held
   // operands, and build the next sum image with only that slice replaced.
   // Constant-index AND/OR selection keeps the mux free of variable part-selects.
   always_comb begin
      chunk_a_s  = {N_W{1'b0}};
      chunk_b_s  = {N_W{1'b0}};
      sum_next_s = sum_r;
      for (int i = 0; i < CHUNKS; i++) begin
         chunk_a_s = chunk_a_s | (a_r[i*N_W +: N_W] & {N_W{idx_r == IDX_W'(i)}});
         chunk_b_s = chunk_b_s | (b_r[i*N_W +: N_W] & {N_W{idx_r == IDX_W'(i)}});
         sum_next_s[i*N_W +: N_W] = (idx_r == IDX_W'(i)) ? add_sum
                                                         : sum_r[i*N_W +: N_W];
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_valid_s) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (last_chunk_s) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output logic. The adder inputs are forced to zero outside RUN and the
   // response fields are zero unless a result is being presented.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      add_a      = {N_W{1'b0}};
      add_b      = {N_W{1'b0}};
      add_c      = 1'b0;
      rsp_valid  = 1'b0;
      rsp_id     = 1'b0;
      rsp_sum    = {OP_W{1'b0}};
      rsp_carry  = 1'b0;
      case (state_r)
         IDLE: begin
            req0_ready = grant_valid_s && (grant_s == 1'b0);
            req1_ready = grant_valid_s && (grant_s == 1'b1);
         end
         RUN: begin
            add_a = chunk_a_s;
            add_b = chunk_b_s;
            add_c = carry_r;
         end
         DONE: begin
            rsp_valid = 1'b1;
            rsp_id    = id_r;
            rsp_sum   = sum_r;
            rsp_carry = carry_r;
         end
         default: begin
            rsp_valid = 1'b0;
         end
      endcase
   end

   // Datapath registers: capture operands on acceptance, then fold one adder
   // result per RUN cycle into the sum image and the carry register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r          <= {OP_W{1'b0}};
         b_r          <= {OP_W{1'b0}};
         sum_r        <= {OP_W{1'b0}};
         carry_r      <= 1'b0;
         idx_r        <= {IDX_W{1'b0}};
         id_r         <= 1'b0;
         last_grant_r <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_valid_s) begin
                  a_r          <= acc_a_s;
                  b_r          <= acc_b_s;
                  id_r         <= grant_s;
                  last_grant_r <= grant_s;
                  idx_r        <= {IDX_W{1'b0}};
                  carry_r      <= 1'b0;
               end else begin
                  idx_r        <= idx_r;
               end
            end
            RUN: begin
               sum_r   <= sum_next_s;
               carry_r <= add_carry;
               // The final chunk leaves idx in place; it is reloaded on accept.
               if (!last_chunk_s) begin
                  idx_r <= idx_r + IDX_W'(1);
               end else begin
                  idx_r <= idx_r;
               end
            end
            default: begin
               idx_r <= idx_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_share_sequencer.sv
module tb_adder_share_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- main DUT: N_W=2, CHUNKS=4 (OP_W=8) ----------------
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0] add_a, add_b, add_sum;
   logic       add_c, add_carry;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
   logic [7:0] rsp_sum;

   // External shared adder model
   assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {2'b00, add_c};

   adder_share_sequencer #(.N_W(2), .CHUNKS(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_sum(add_sum), .add_carry(add_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
   );

   // ---------------- second DUT: N_W=2, CHUNKS=1 (OP_W=2) ----------------
   logic       c1_req0_valid, c1_req0_ready, c1_req1_valid, c1_req1_ready;
   logic [1:0] c1_req0_a, c1_req0_b, c1_req1_a, c1_req1_b;
   logic [1:0] c1_add_a, c1_add_b, c1_add_sum;
   logic       c1_add_c, c1_add_carry;
   logic       c1_rsp_valid, c1_rsp_ready, c1_rsp_id, c1_rsp_carry;
   logic [1:0] c1_rsp_sum;

   assign {c1_add_carry, c1_add_sum} = {1'b0, c1_add_a} + {1'b0, c1_add_b} + {2'b00, c1_add_c};

   adder_share_sequencer #(.N_W(2), .CHUNKS(1)) dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(c1_req0_valid), .req0_ready(c1_req0_ready), .req0_a(c1_req0_a), .req0_b(c1_req0_b),
      .req1_valid(c1_req1_valid), .req1_ready(c1_req1_ready), .req1_a(c1_req1_a), .req1_b(c1_req1_b),
      .add_a(c1_add_a), .add_b(c1_add_b), .add_c(c1_add_c), .add_sum(c1_add_sum), .add_carry(c1_add_carry),
      .rsp_valid(c1_rsp_valid), .rsp_ready(c1_rsp_ready), .rsp_id(c1_rsp_id),
      .rsp_sum(c1_rsp_sum), .rsp_carry(c1_rsp_carry)
   );

   task automatic clear_inputs();
      req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00;
      req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
      rsp_ready  = 1'b0;
      c1_req0_valid = 1'b0; c1_req0_a = 2'd0; c1_req0_b = 2'd0;
      c1_req1_valid = 1'b0; c1_req1_a = 2'd0; c1_req1_b = 2'd0;
      c1_rsp_ready  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [16:0] obs;
      @(negedge clk);
      #1;
      obs = {rsp_valid, rsp_id, rsp_carry, rsp_sum, add_a, add_b, add_c, req0_ready, req1_ready};
      checks++;
      if (obs !== 17'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", obs);
      end
      obs = {6'h0, c1_rsp_valid, c1_rsp_id, c1_rsp_carry, c1_rsp_sum, c1_add_a, c1_add_b, c1_add_c};
      checks++;
      if (obs !== 17'h0) begin
         errors++;
         $display("FAIL reset_outputs_c1: got %h expected 0", obs);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [3:0] exp_c = 4'b1110;   // carry-in per RUN cycle, cycle 0 in bit 0
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01; rsp_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL basic_accept: got %b expected 10", {req0_ready, req1_ready});
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req0_valid = 1'b0;
         #1;
         checks++;
         if ({add_a, add_b, add_c} !== {2'd3, (k == 0) ? 2'd1 : 2'd0, exp_c[k]}) begin
            errors++;
            $display("FAIL basic_run%0d: got a=%0d b=%0d c=%0d expected a=3 b=%0d c=%0d",
                     k, add_a, add_b, add_c, (k == 0) ? 1 : 0, exp_c[k]);
         end
         checks++;
         if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
            errors++;
            $display("FAIL basic_run_quiet%0d: got %b expected 000", k, {rsp_valid, req0_ready, req1_ready});
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL basic_rsp: got v=%b id=%b c=%b sum=%h expected v=1 id=0 c=1 sum=00",
                  rsp_valid, rsp_id, rsp_carry, rsp_sum);
      end
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_rsp_drop: got %b expected 0", rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic       exp_id  [3] = '{1'b0, 1'b1, 1'b0};
      logic [7:0] exp_sum [3] = '{8'h46, 8'h00, 8'h46};
      logic       exp_cy  [3] = '{1'b0, 1'b1, 1'b0};
      do_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
      req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h80;
      rsp_ready  = 1'b1;
      for (int op = 0; op < 3; op++) begin
         #1;
         checks++;
         if ({req0_ready, req1_ready} !== (exp_id[op] ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL b2b_grant%0d: got %b expected id %0d", op, {req0_ready, req1_ready}, exp_id[op]);
         end
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
               errors++;
               $display("FAIL b2b_run%0d_%0d: got %b expected 000", op, k, {req0_ready, req1_ready, rsp_valid});
            end
         end
         @(negedge clk);
         #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== {1'b1, exp_id[op], exp_cy[op], exp_sum[op]}) begin
            errors++;
            $display("FAIL b2b_rsp%0d: got v=%b id=%b c=%b sum=%h expected v=1 id=%b c=%b sum=%h",
                     op, rsp_valid, rsp_id, rsp_carry, rsp_sum, exp_id[op], exp_cy[op], exp_sum[op]);
         end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h5A; rsp_ready = 1'b0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL bp_accept: got %b expected 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h01;
         #1;
         checks++;
         if ({rsp_valid, rsp_carry, rsp_sum, req0_ready, req1_ready} !== {1'b1, 1'b0, 8'hFF, 2'b00}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b c=%b sum=%h rdy=%b expected v=1 c=0 sum=ff rdy=00",
                     k, rsp_valid, rsp_carry, rsp_sum, {req0_ready, req1_ready});
         end
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL bp_release: got %b expected 10", {rsp_valid, req1_ready});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, req1_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_idle: got %b expected 01", {rsp_valid, req1_ready});
      end
      req1_valid = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [16:0] obs;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01; rsp_ready = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({add_a, add_c} !== {2'd3, 1'b1}) begin
         errors++;
         $display("FAIL mid_run_pre: got a=%0d c=%0d expected a=3 c=1", add_a, add_c);
      end
      rst = 1'b1;
      #1;
      obs = {rsp_valid, rsp_id, rsp_carry, rsp_sum, add_a, add_b, add_c, req0_ready, req1_ready};
      checks++;
      if (obs !== 17'h0) begin
         errors++;
         $display("FAIL mid_run_async: got %h expected 0", obs);
      end
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
      req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h80;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL mid_run_regrant: got %b expected 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== {1'b1, 1'b0, 1'b0, 8'h46}) begin
         errors++;
         $display("FAIL mid_run_rsp: got v=%b id=%b c=%b sum=%h expected v=1 id=0 c=0 sum=46",
                  rsp_valid, rsp_id, rsp_carry, rsp_sum);
      end
   endtask

   task automatic test_operand_change();
      @(negedge clk);
      req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h01; rsp_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         errors++;
         $display("FAIL opchg_accept: got %b expected 01", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req1_valid = 1'b0; req1_a = 8'hFF; req1_b = 8'hFF;
      repeat (3) @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== {1'b1, 1'b1, 1'b0, 8'h10}) begin
         errors++;
         $display("FAIL opchg_rsp: got v=%b id=%b c=%b sum=%h expected v=1 id=1 c=0 sum=10",
                  rsp_valid, rsp_id, rsp_carry, rsp_sum);
      end
      @(negedge clk);
   endtask

   task automatic test_single_chunk();
      @(negedge clk);
      c1_req0_valid = 1'b1; c1_req0_a = 2'd3; c1_req0_b = 2'd3; c1_rsp_ready = 1'b1;
      #1;
      checks++;
      if ({c1_req0_ready, c1_add_a, c1_add_b, c1_add_c} !== {1'b1, 5'b0}) begin
         errors++;
         $display("FAIL c1_accept: got rdy=%b a=%0d b=%0d c=%0d expected rdy=1 a=0 b=0 c=0",
                  c1_req0_ready, c1_add_a, c1_add_b, c1_add_c);
      end
      @(negedge clk);
      c1_req0_valid = 1'b0;
      #1;
      checks++;
      if ({c1_rsp_valid, c1_add_a, c1_add_b, c1_add_c} !== {1'b0, 2'd3, 2'd3, 1'b0}) begin
         errors++;
         $display("FAIL c1_run: got v=%b a=%0d b=%0d c=%0d expected v=0 a=3 b=3 c=0",
                  c1_rsp_valid, c1_add_a, c1_add_b, c1_add_c);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({c1_rsp_valid, c1_rsp_id, c1_rsp_carry, c1_rsp_sum, c1_add_a, c1_add_b, c1_add_c}
          !== {1'b1, 1'b0, 1'b1, 2'd2, 5'b0}) begin
         errors++;
         $display("FAIL c1_rsp: got v=%b id=%b c=%b sum=%0d adder=%b expected v=1 id=0 c=1 sum=2 adder=0",
                  c1_rsp_valid, c1_rsp_id, c1_rsp_carry, c1_rsp_sum, {c1_add_a, c1_add_b, c1_add_c});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({c1_rsp_valid, c1_add_a, c1_add_b, c1_add_c} !== 6'b0) begin
         errors++;
         $display("FAIL c1_idle: got v=%b adder=%b expected all 0",
                  c1_rsp_valid, {c1_add_a, c1_add_b, c1_add_c});
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_chunk();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_run();
      test_operand_change();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
